irq_arbiter: RTL
================

# irq_arbiter

Interrupt controller between the peripheral devices (two COCO timers plus up to four further sources) and CP0 of the pipelined MIPS CPU. It latches up to six hardware interrupt lines and applies a software mask, edge/level mode and fixed priority. It presents one request with an ID to CP0 and tracks the in-service interrupt until `eret`. It is memory-mapped on the same device bus as the timers and is programmed with word accesses.

## Interface
- `NIRQ`, default 6: number of interrupt inputs. The maximum is 6, matching the CP0 HWInt width.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `irq_in`  in  NIRQ  raw device interrupt lines. Bit 0 is the highest priority.
- `we`  in  1  bus write enable.
- `addr`  in  [3:2]  register select.
- `WD`  in  32  bus write data.
- `RD`  out  32  bus read data. It is combinational from `addr`.
- `int_req`  out  1  interrupt request to CP0.
- `int_id`  out  3  index of the requested interrupt. It is valid while `int_req`=1.
- `int_ack`  in  1  one-cycle pulse from CP0 when the exception is taken.
- `eret`  in  1  one-cycle pulse when the handler executes `eret`.
- `HWInt`  out  NIRQ  equals `PEND & MASK`. It is mirrored to CP0 Cause.IP.

## Operation
- **Registers.** Unimplemented bits read 0.
  - `addr` 0, MASK[NIRQ-1:0]: read/write. 1 enables the line.
  - `addr` 1, PEND: read. A write of 1 to a bit clears that bit in edge mode. Writes have no effect in level mode.
  - `addr` 2, MODE: read/write. 1 = edge-triggered, 0 = level.
  - `addr` 3, STAT: read-only. Bit 31 = in service. Bits [2:0] = in-service ID. Writes are ignored.
- **Input path.**
  - `irq_in` passes through one synchronizer register `s`.
  - A previous-value register `p` follows `s`.
  - The edge condition is `s & ~p`.
- **PEND update, per bit.**
  - Level mode: PEND ← `s`.
  - Edge mode: PEND is set when an edge is detected. It is cleared by a W1C write or by `int_ack` for that ID.
  - If a set and a clear happen in the same cycle, the set wins.
- **Mode change.** Switching a bit from edge to level makes PEND follow `s` from the next cycle.
- **Priority.** `eligible` = `PEND & MASK`. `int_id` is the lowest set index of `eligible`. It is recomputed every cycle.
- **FSM states: IDLE, REQ, SERV.**
  - IDLE → REQ when `eligible` ≠ 0.
  - REQ → SERV on `int_ack`. On this transition the block captures `int_id` into the in-service ID, sets STAT[31], and clears the PEND bit if that line is in edge mode.
  - REQ → IDLE if `eligible` becomes 0 before `int_ack`. This covers software clear and masking.
  - SERV → IDLE on `eret`. STAT[31] is cleared.
  - `int_ack` outside REQ is ignored. `eret` outside SERV is ignored.
  - There is no nesting: new interrupts stay pending while the FSM is in SERV.
- **Outputs.**
  - `int_req` = (state == REQ).
  - `int_id` = 0 when `int_req` = 0.
- **Reset.** Any assertion, including mid-service, immediately clears all of the following: `s`, `p`, PEND, MASK, MODE, in-service ID, and STAT. The FSM goes to IDLE, so `int_req`, `int_id`, `HWInt` and `RD`'s register contents are all 0. A pending interrupt is lost.
- **Bus.** Register writes take effect at the clock edge where `we`=1. A bus write and a hardware update to the same cycle are both applied, with the precedence given above.

## Timing
- **Latency.** If `irq_in[i]` rises before edge n, then `s` updates at edge n and PEND[i] at edge n+1. If MASK[i] is set, the FSM enters REQ at edge n+2, so `int_req` is high after edge n+2. This is two cycles of latency from the synchronizer edge.
- **Acknowledge.** `int_ack` sampled at edge k moves the FSM to SERV. `int_req` drops after edge k, and the edge-mode PEND bit clears at edge k.
- **Return.** `eret` at edge k → IDLE at edge k. If `eligible` ≠ 0 at that point, REQ follows at edge k+1.
- **Priority switch.** A higher-priority arrival during REQ changes `int_id` combinationally the cycle after its PEND bit sets. `int_ack` captures whatever value is current at that edge.
- **Reads.** `RD` has zero latency. A register reads its new value the cycle after the write.
- **Level sources.** The timer IRQ is level. It must be cleared at the source before `eret`, otherwise the controller re-requests one cycle after `eret`.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-cycle while in SERV → `int_req`=0, STAT=0, and MASK, MODE, PEND all read 0 immediately.
- **Edge request/ack.** MASK=6'h3F, MODE=6'h3F. Pulse `irq_in[2]` for 1 cycle → `int_req`=1 with `int_id`=2 two cycles after sync. Then `int_ack` → PEND[2]=0, STAT=32'h8000_0002. Then `eret` → STAT=0 and `int_req` stays 0.
- **Priority.** Set edge-mode `irq_in[4]` and `irq_in[1]` in the same cycle → `int_id`=1. After its `eret`, `int_req` returns with `int_id`=4 one cycle later.
- **Masking and abort.** MASK=0, PEND[3]=1 → `int_req`=0 while HWInt=0 and PEND reads 6'h08. Set MASK[3] → REQ. Write PEND=6'h08 (W1C) before ack → back to IDLE, `int_req`=0.
- **Level mode with timer.** MODE=0, with the timer IRQ on `irq_in[0]` held high → after ack and `eret` with the IRQ still high, `int_req` reasserts the next cycle. Once the IRQ drops, PEND[0]=0 one cycle after `s` falls.
- **Simultaneous events.** A W1C write to PEND[5] in the same cycle as a new edge on line 5 → PEND[5] stays 1. `int_ack` arriving while the FSM is in IDLE → no state change.

Source files
------------

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - six-line interrupt arbiter between bus devices and CP0
module irq_arbiter #(
    parameter int NIRQ = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            we,
    input  logic [3:2]      addr,
    input  logic [31:0]     WD,
    output logic [31:0]     RD,
    output logic            int_req,
    output logic [2:0]      int_id,
    input  logic            int_ack,
    input  logic            eret,
    output logic [NIRQ-1:0] HWInt
);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t          state;
    logic [NIRQ-1:0] s, p, pend, mask, mode;
    logic [NIRQ-1:0] eligible, edge_set, w1c, ack_clr, pend_next;
    logic [2:0]      serv_id;
    logic            ack_take;
    logic            unused_wd;

    assign unused_wd = ^WD[31:NIRQ];

    assign eligible = pend & mask;
    assign HWInt    = eligible;
    assign int_req  = (state == REQ);
    // Abort takes precedence: an ack seen after eligible has drained is dropped.
    assign ack_take = int_req && int_ack && (|eligible);

    always_comb begin
        int_id = 3'd0;
        if (int_req) begin
            for (int i = NIRQ - 1; i >= 0; i--) begin
                if (eligible[i]) int_id = 3'(i);
            end
        end
    end

    // Edge bits: set beats clear. Level bits just track the synchronizer.
    always_comb begin
        edge_set  = s & ~p;
        w1c       = (we && addr == 2'd1) ? WD[NIRQ-1:0] : '0;
        ack_clr   = ack_take ? ({{(NIRQ-1){1'b0}}, 1'b1} << int_id) : '0;
        pend_next = (mode & (edge_set | (pend & ~(w1c | ack_clr)))) | (~mode & s);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s       <= '0;
            p       <= '0;
            pend    <= '0;
            mask    <= '0;
            mode    <= '0;
            serv_id <= 3'd0;
            state   <= IDLE;
        end else begin
            s    <= irq_in;
            p    <= s;
            pend <= pend_next;
            if (we && addr == 2'd0) mask <= WD[NIRQ-1:0];
            if (we && addr == 2'd2) mode <= WD[NIRQ-1:0];
            case (state)
                IDLE: if (|eligible) state <= REQ;
                REQ: begin
                    if (!(|eligible)) begin
                        state <= IDLE;
                    end else if (int_ack) begin
                        state   <= SERV;
                        serv_id <= int_id;
                    end
                end
                SERV: begin
                    if (eret) begin
                        state   <= IDLE;
                        serv_id <= 3'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        RD = 32'd0;
        case (addr)
            2'd0: RD[NIRQ-1:0] = mask;
            2'd1: RD[NIRQ-1:0] = pend;
            2'd2: RD[NIRQ-1:0] = mode;
            default: RD = {(state == SERV), 28'd0, serv_id};
        endcase
    end

endmodule
